// File: rtl/rr_mux_arb.sv
// -----------------------------------------------------------------------------
// rr_mux_arb
//   Parametrised N:1 registered multiplexer with a valid/ready handshake on
//   every input channel and on the single output. Each cycle in which the
//   output register can accept a word, one requesting channel is granted.
//   The grant is round-robin (MODE=0) or fixed priority with the lowest index
//   winning (MODE=1). The granted word is captured into the output register,
//   so there is one cycle of latency and one word per cycle of throughput.
//
// Parameters
//   N     number of input channels (>= 2)
//   W     data width per channel
//   MODE  0 = round-robin, 1 = fixed priority (lowest index wins)
//   SELW  width of out_sel, derived from N (do not override)
//
// Ports
//   clk        in   1     clock, all state on the rising edge
//   rst        in   1     asynchronous, active-high reset
//   in_valid   in   N     channel i presents data on in_data[i*W +: W]
//   in_ready   out  N     channel i is accepted this cycle (one-hot or zero)
//   in_data    in   N*W   packed channel data, channel 0 in the LSBs
//   out_valid  out  1     out_data/out_sel hold a valid word
//   out_ready  in   1     consumer takes the word this cycle
//   out_data   out  W     registered data of the granted channel
//   out_sel    out  SELW  index of the channel that produced out_data
// -----------------------------------------------------------------------------
module rr_mux_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel
);

  // Channel count and last index at the widths used by the scan arithmetic.
  localparam logic [SELW:0]   N_WIDE   = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N-1);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            ld_s;
  logic [SELW-1:0] scan_base_s;
  logic            gnt_found_s;
  logic [SELW-1:0] gnt_idx_s;
  logic [W-1:0]    gnt_data_s;

  // The output register can take a new word when empty or being drained now.
  assign ld_s = ~out_valid_q | out_ready;

  // Round-robin scans from the pointer; fixed priority always scans from 0.
  always_comb begin
    if (MODE == 1) begin
      scan_base_s = '0;
    end else begin
      scan_base_s = ptr_q;
    end
  end

  // Find the first valid channel starting at scan_base_s, wrapping past N-1.
  // The sum is one bit wider so base+k never overflows before the wrap.
  always_comb begin
    logic [SELW:0] cand;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, scan_base_s} + (SELW+1)'(k);
      if (cand >= N_WIDE) begin
        cand = cand - N_WIDE;
      end else begin
        cand = cand;
      end
      if (!gnt_found_s && in_valid[cand[SELW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand[SELW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Select the data word of the granted channel.
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx_s == SELW'(i)) begin
        gnt_data_s = in_data[i*W +: W];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // One-hot ready to the granted channel; forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (!rst && ld_s && gnt_found_s) begin
      in_ready[gnt_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (ld_s && gnt_found_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_s;
      out_sel_d   = gnt_idx_s;
      if (MODE == 0) begin
        // Pointer moves just past the winner so it becomes lowest priority.
        if (gnt_idx_s == LAST_IDX) begin
          ptr_d = '0;
        end else begin
          ptr_d = gnt_idx_s + SELW'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else if (ld_s) begin
      // Drained (or already empty) with nothing to load: data/sel keep last value.
      out_valid_d = 1'b0;
    end else begin
      // Backpressure: everything holds.
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arb
//   Three instances: u0 round-robin N=4 W=8, u1 fixed priority N=4 W=8,
//   u2 round-robin N=3 W=16. A reference model (queue-free, index arithmetic
//   with modulo) tracks each instance; one process compares every output on
//   every falling edge. Directed vectors add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_rr_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  iv0, iv1;
  logic [2:0]  iv2;
  logic [31:0] id0, id1;
  logic [47:0] id2;
  logic        ordy0, ordy1, ordy2;
  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2;
  logic        ov0, ov1, ov2;
  logic [7:0]  od0, od1;
  logic [15:0] od2;
  logic [1:0]  os0, os1, os2;

  rr_mux_arb #(.N(4), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_sel(os0));
  rr_mux_arb #(.N(4), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_sel(os1));
  rr_mux_arb #(.N(3), .W(16), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_sel(os2));

  localparam int MN[3] = '{4, 4, 3};
  localparam int MM[3] = '{0, 1, 0};

  // Uniform views of the three instances for the model and the compare loop.
  logic [3:0]  vld [3];
  logic [15:0] dat [3][4];
  logic        rdy [3];
  logic [3:0]  irv [3];
  logic        ovv [3];
  logic [15:0] odv [3];
  int          osv [3];

  always_comb begin
    vld[0] = iv0; vld[1] = iv1; vld[2] = {1'b0, iv2};
    rdy[0] = ordy0; rdy[1] = ordy1; rdy[2] = ordy2;
    irv[0] = ir0; irv[1] = ir1; irv[2] = {1'b0, ir2};
    ovv[0] = ov0; ovv[1] = ov1; ovv[2] = ov2;
    odv[0] = {8'h00, od0}; odv[1] = {8'h00, od1}; odv[2] = od2;
    osv[0] = int'(os0); osv[1] = int'(os1); osv[2] = int'(os2);
    for (int c = 0; c < 4; c++) begin
      dat[0][c] = {8'h00, id0[c*8 +: 8]};
      dat[1][c] = {8'h00, id1[c*8 +: 8]};
    end
    for (int c = 0; c < 3; c++) begin
      dat[2][c] = id2[c*16 +: 16];
    end
    dat[2][3] = 16'h0000;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel that must win: first valid one scanning from the start index, wrapping.
  function automatic int mgrant(input int n, input int mode, input int ptr, input logic [3:0] v);
    int start;
    start = (mode == 1) ? 0 : ptr;
    for (int k = 0; k < n; k++) begin
      if (v[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  // Model state per instance.
  logic        m_v    [3];
  logic [15:0] m_data [3];
  int          m_sel  [3];
  int          m_ptr  [3];

  task automatic model_reset(input int j);
    m_v[j] = 1'b0; m_data[j] = 16'h0000; m_sel[j] = 0; m_ptr[j] = 0;
  endtask

  // Model update on rising edges, full output comparison on falling edges.
  initial begin
    for (int j = 0; j < 3; j++) model_reset(j);
    forever begin
      @(posedge clk or negedge clk);
      for (int j = 0; j < 3; j++) begin
        logic ld;
        int g;
        logic [3:0] e_ir;
        if (rst) model_reset(j);
        ld = !m_v[j] || rdy[j];
        g  = ld ? mgrant(MN[j], MM[j], m_ptr[j], vld[j]) : -1;
        if (clk) begin
          if (!rst && ld) begin
            if (g >= 0) begin
              m_v[j] = 1'b1; m_data[j] = dat[j][g]; m_sel[j] = g;
              if (MM[j] == 0) m_ptr[j] = (g + 1) % MN[j];
            end else begin
              m_v[j] = 1'b0;
            end
          end
        end else begin
          e_ir = (rst || g < 0) ? 4'b0000 : 4'(1 << g);
          check($sformatf("u%0d in_ready", j), {28'h0, irv[j]}, {28'h0, e_ir});
          check($sformatf("u%0d out_valid", j), {31'h0, ovv[j]}, {31'h0, m_v[j]});
          check($sformatf("u%0d out_data", j), {16'h0, odv[j]}, {16'h0, m_data[j]});
          check($sformatf("u%0d out_sel", j), osv[j], m_sel[j]);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  localparam logic [7:0]  E_SEL0 [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
  localparam logic [7:0]  E_DAT0 [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
  localparam logic [7:0]  E_SEL2 [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
  localparam logic [15:0] E_DAT2 [6] = '{16'h1A00, 16'h1A01, 16'h1A02, 16'h1A00, 16'h1A01, 16'h1A02};

  initial begin
    rst = 1'b0;
    iv0 = 4'h0; iv1 = 4'h0; iv2 = 3'h0;
    id0 = 32'h0; id1 = 32'h0; id2 = 48'h0;
    ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("reset out_valid", {31'h0, ov0}, 32'd0);
    check("reset in_ready", {28'h0, ir0}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Round-robin over all four channels, one word per cycle.
    iv0 = 4'hF; id0 = 32'hA3A2A1A0;
    smp();
    check("first grant ch0", {28'h0, ir0}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      smp();
      check("rr out_valid", {31'h0, ov0}, 32'd1);
      check("rr out_sel", {30'h0, os0}, {24'h0, E_SEL0[k]});
      check("rr out_data", {24'h0, od0}, {24'h0, E_DAT0[k]});
    end
    nxt(); iv0 = 4'h0;
    smp();
    check("last word sel", {30'h0, os0}, 32'd0);
    smp();
    check("idle out_valid", {31'h0, ov0}, 32'd0);
    check("idle data hold", {24'h0, od0}, 32'hA0);
    check("idle model ptr", m_ptr[0], 32'd1);

    // Move the pointer to 3, then skip and wrap.
    nxt(); iv0 = 4'b0100;
    smp();
    check("grant ch2", {28'h0, ir0}, 32'b0100);
    nxt(); iv0 = 4'b0010; id0 = 32'hA3A255A0;
    smp();
    check("skip grant ch1", {28'h0, ir0}, 32'b0010);
    check("ch2 word sel", {30'h0, os0}, 32'd2);
    nxt(); iv0 = 4'b1001;
    smp();
    check("ch1 data 55", {24'h0, od0}, 32'h55);
    check("ch1 sel", {30'h0, os0}, 32'd1);
    check("ptr after ch1", m_ptr[0], 32'd2);
    check("wrap grant ch3", {28'h0, ir0}, 32'b1000);
    nxt(); iv0 = 4'b0001;
    smp();
    check("ch3 sel", {30'h0, os0}, 32'd3);
    check("then ch0", {28'h0, ir0}, 32'b0001);
    nxt(); iv0 = 4'b0000;
    smp();
    check("ch0 sel", {30'h0, os0}, 32'd0);

    // Backpressure for five cycles, then drain and load together.
    nxt(); iv0 = 4'hF; id0 = 32'hA3A2A1A0; ordy0 = 1'b0;
    smp();
    check("bp first grant ch1", {28'h0, ir0}, 32'b0010);
    for (int k = 0; k < 5; k++) begin
      smp();
      check("bp out_valid", {31'h0, ov0}, 32'd1);
      check("bp out_sel", {30'h0, os0}, 32'd1);
      check("bp out_data", {24'h0, od0}, 32'hA1);
      check("bp in_ready", {28'h0, ir0}, 32'd0);
    end
    nxt(); ordy0 = 1'b1;
    smp();
    check("drain grant ch2", {28'h0, ir0}, 32'b0100);
    nxt(); iv0 = 4'h0;
    smp();
    check("no bubble valid", {31'h0, ov0}, 32'd1);
    check("no bubble sel", {30'h0, os0}, 32'd2);
    check("no bubble data", {24'h0, od0}, 32'hA2);

    // Fixed priority: ch1 beats ch3 until ch1 drops.
    nxt(); iv1 = 4'b1010; id1 = 32'hB3B2B1B0;
    smp();
    check("fp grant ch1", {28'h0, ir1}, 32'b0010);
    for (int k = 0; k < 3; k++) begin
      smp();
      check("fp keeps ch1", {28'h0, ir1}, 32'b0010);
      check("fp out_sel", {30'h0, os1}, 32'd1);
    end
    nxt(); iv1 = 4'b1000;
    smp();
    check("fp grant ch3", {28'h0, ir1}, 32'b1000);
    nxt(); iv1 = 4'b0000;
    smp();
    check("fp ch3 sel", {30'h0, os1}, 32'd3);
    check("fp ch3 data", {24'h0, od1}, 32'hB3);
    check("fp ptr stays 0", m_ptr[1], 32'd0);

    // Non-power-of-two wrap with N=3, W=16.
    nxt(); iv2 = 3'b111; id2 = {16'h1A02, 16'h1A01, 16'h1A00};
    smp();
    check("n3 first grant", {29'h0, ir2}, 32'b001);
    for (int k = 0; k < 6; k++) begin
      smp();
      check("n3 out_sel", {30'h0, os2}, {24'h0, E_SEL2[k]});
      check("n3 out_data", {16'h0, od2}, {16'h0, E_DAT2[k]});
    end
    nxt(); iv2 = 3'b000;

    // Asynchronous reset in the middle of a stream.
    iv0 = 4'hF; ordy0 = 1'b1;
    smp(); smp();
    check("pre-reset valid", {31'h0, ov0}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst out_valid", {31'h0, ov0}, 32'd0);
    check("async rst in_ready", {28'h0, ir0}, 32'd0);
    check("async rst out_sel", {30'h0, os0}, 32'd0);
    check("async rst out_data", {24'h0, od0}, 32'd0);
    nxt(); nxt();
    rst = 1'b0;
    smp();
    check("post-reset grant ch0", {28'h0, ir0}, 32'b0001);
    nxt(); iv0 = 4'h0;
    smp(); smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
